vga_compositor: RTL and testbench
=================================

VGA_COMPOSITOR -- requirements
Module: vga_compositor

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels.
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
- CW 4: bits per colour channel, 1..8.
- RD_LAT 1: layer-colour return latency in pix_ce ticks, 1..3.
- BLINK_SH 5: frame_cnt bit that gates cursor blink.
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 Ports (name, direction, width, meaning):
- clk in 1: system clock.
- rst in 1: synchronous reset.
- pix_ce in 1: pixel-tick enable.
- we_reg in 1: register write strobe.
- irq_clr in 1: clears irq.
- data_in in 32: register write data.
- col_o out 11: pixel column request.
- row_o out 11: pixel row request.
- text_color in 3*CW: text layer colour.
- graph_color in 3*CW: graphics layer colour.
- cursor_color in 3*CW: cursor layer colour.
- r out CW, g out CW, b out CW: pixel colour.
- hsync out 1, vsync out 1: active-low syncs.
- irq out 1: vblank interrupt.
- vga_status out 32: status word.

Function
REQ-004 State advances only on clk edges with pix_ce=1; with pix_ce=0 all state holds, except register writes and irq_clr, which act on any clk edge.
REQ-005 hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params), then wraps to 0 and advances vcnt; vcnt wraps from V_TOTAL-1 to 0.
REQ-006 col_o=hcnt and row_o=vcnt, driven combinationally from the counters.
REQ-007 active = (hcnt<H_ACTIVE) and (vcnt<V_ACTIVE).
- hs_raw is low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
- vs_raw is low over the equivalent vcnt range.
REQ-008 Layer colours for a given (col_o,row_o) are valid exactly RD_LAT ticks later; active, hs_raw and vs_raw pass through an RD_LAT-stage delay line to stay aligned with them.
REQ-009 r/g/b/hsync/vsync are registered, giving a total latency of RD_LAT+1 ticks from counter to pins.
REQ-010 Shadow config is written from data_in on we_reg. Field layout:
- [1:0] mode: 00 text, 01 graph, 10 text+cursor, 11 background.
- [2] blink_en.
- [3] irq_en.
- [8 +: 3*CW] background colour as {R,G,B}.
REQ-011 Active config loads from the shadow only at the vblank-start tick (hcnt=0, vcnt=V_ACTIVE), so mode never changes mid-frame.
REQ-012 The pending flag behaves as follows:
- Set on write; cleared on the load tick.
- If a write coincides with the load tick, the active config takes the old shadow, the shadow takes the new value, and pending stays 1.
REQ-013 Pixel output when the delayed active flag = 0: r=g=b=0.
REQ-014 Pixel output when active, by mode:
- 00: text_color.
- 01: graph_color.
- 11: background colour.
- 10: cursor_color if it is nonzero and cursor_vis, else text_color.
REQ-015 cursor_vis = ~blink_en | ~frame_cnt[BLINK_SH].
REQ-016 frame_cnt is 16 bits; it increments on the vblank-start tick and wraps from 0xFFFF to 0.
REQ-017 irq behaviour:
- Set on the vblank-start tick when active irq_en=1.
- Cleared by irq_clr.
- A simultaneous set and clear leaves irq=1.
REQ-018 vga_status = {frame_cnt[15:0], 11'b0, irq, pending, in_vblank, active mode[1:0]}, where in_vblank = (vcnt >= V_ACTIVE).

Reset
REQ-019 On reset:
- hcnt, vcnt, frame_cnt, shadow config, active config, pending, irq and all delay stages are cleared to 0.
- r=g=b=0, hsync=1, vsync=1.
REQ-020 Reset asserted mid-frame takes effect on the next clk edge regardless of pix_ce, and any pending shadow write is discarded.

Verification
REQ-021 Default parameters, pix_ce=1 constantly:
- hsync low for 96 clocks starting at hcnt=656+RD_LAT+1 relative to line start.
- Line period 800 clocks; frame period 525 lines.
REQ-022 Write mode=01 at mid-frame (vcnt=100) -> output still follows text_color until the tick after vcnt=480,hcnt=0; then pending=0 and status[1:0]=01.
REQ-023 Mode=10, blink_en=1, cursor_color=0xF00, text_color=0x0F0 -> output is 0xF00 while frame_cnt[5]=0 and 0x0F0 while frame_cnt[5]=1; 0x0F0 wherever cursor_color=0.
REQ-024 irq_en=1; assert irq_clr on the vblank-start tick -> irq stays 1; irq_clr on the next cycle -> irq=0.
REQ-025 RD_LAT=3, pix_ce toggling every other clk:
- Layer colour presented 3 ticks after col_o=0 appears at r/g/b on tick 4.
- Nothing advances on pix_ce=0 cycles.
REQ-026 Assert rst at vcnt=200 with a shadow write pending -> next cycle: counters=0, status=0, outputs 0, syncs=1.

Source files
------------

// File: rtl/vga_compositor.sv
// vga_compositor: VGA timing generator that composites text, graphics, cursor and background layers.
module vga_compositor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CW = 4,
  parameter int RD_LAT = 1,
  parameter int BLINK_SH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_ce,
  input  logic we_reg,
  input  logic irq_clr,
  input  logic [31:0] data_in,
  output logic [10:0] col_o,
  output logic [10:0] row_o,
  input  logic [3*CW-1:0] text_color,
  input  logic [3*CW-1:0] graph_color,
  input  logic [3*CW-1:0] cursor_color,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic hsync,
  output logic vsync,
  output logic irq,
  output logic [31:0] vga_status
);
  localparam int CFG_W = 8 + 3*CW;
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HL = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [10:0] hcnt, vcnt;
  logic [15:0] frame_cnt;
  logic [CFG_W-1:0] shadow, cfg;
  logic pending;
  logic active, hs_on, vs_on, load, cursor_vis;
  logic [3*CW-1:0] sel;
  // delay lines hold sync as active-high pulses so a cleared stage means "no sync"
  logic [RD_LAT-1:0] act_d, hs_d, vs_d;
  logic unused_bits;
  assign unused_bits = ^{data_in[7:4], data_in >> CFG_W};
  assign col_o = hcnt;
  assign row_o = vcnt;
  assign vga_status = {frame_cnt, 11'b0, irq, pending, vcnt >= VA, cfg[1:0]};
  always_comb begin
    active = (hcnt < HA) && (vcnt < VA);
    hs_on = (hcnt >= HS0) && (hcnt < HS1);
    vs_on = (vcnt >= VS0) && (vcnt < VS1);
    load = pix_ce && (hcnt == 11'd0) && (vcnt == VA);
    cursor_vis = ~cfg[2] | ~frame_cnt[BLINK_SH];
    sel = cfg[1:0] == 2'd0 ? text_color :
          cfg[1:0] == 2'd1 ? graph_color :
          cfg[1:0] == 2'd3 ? cfg[CFG_W-1:8] :
          ((|cursor_color) && cursor_vis) ? cursor_color : text_color;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      frame_cnt <= '0;
      shadow <= '0;
      cfg <= '0;
      pending <= 1'b0;
      irq <= 1'b0;
      act_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
      r <= '0;
      g <= '0;
      b <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      if (pix_ce) begin
        hcnt <= (hcnt == HL) ? 11'd0 : hcnt + 11'd1;
        if (hcnt == HL) vcnt <= (vcnt == VL) ? 11'd0 : vcnt + 11'd1;
        act_d <= RD_LAT'({act_d, active});
        hs_d <= RD_LAT'({hs_d, hs_on});
        vs_d <= RD_LAT'({vs_d, vs_on});
        r <= act_d[RD_LAT-1] ? sel[3*CW-1:2*CW] : '0;
        g <= act_d[RD_LAT-1] ? sel[2*CW-1:CW] : '0;
        b <= act_d[RD_LAT-1] ? sel[CW-1:0] : '0;
        hsync <= ~hs_d[RD_LAT-1];
        vsync <= ~vs_d[RD_LAT-1];
      end
      if (load) begin
        cfg <= shadow;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (we_reg) shadow <= data_in[CFG_W-1:0];
      pending <= we_reg | (pending & ~load);
      irq <= (load & cfg[3]) | (irq & ~irq_clr);
    end
  end
endmodule

// File: tb/tb_vga_compositor.sv
// tb_vga_compositor: randomized bench against a tick-count based model of the compositor.
module tb_vga_compositor;
  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2, HT = HA + HFP + HSY + HBP;
  localparam int VA = 12, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int CW = 4, RL = 3, BSH = 1;
  logic clk = 0, rst = 1, pix_ce = 0, we_reg = 0, irq_clr = 0;
  logic [31:0] data_in = 0;
  logic [10:0] col_o, row_o;
  logic [11:0] text_color = 0, graph_color = 0, cursor_color = 0;
  logic [3:0] r, g, b;
  logic hsync, vsync, irq;
  logic [31:0] vga_status;
  int n = 0, total = 0, passed = 0, errors = 0;
  logic [19:0] mshadow = 0, mcfg = 0;
  logic mpend = 0, mirq = 0;
  logic [15:0] mframe = 0;
  logic [3:0] er = 0, eg = 0, eb = 0;
  logic ehs = 1, evs = 1;

  vga_compositor #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CW(CW), .RD_LAT(RL), .BLINK_SH(BSH)) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .we_reg(we_reg), .irq_clr(irq_clr),
    .data_in(data_in), .col_o(col_o), .row_o(row_o), .text_color(text_color),
    .graph_color(graph_color), .cursor_color(cursor_color), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .irq(irq), .vga_status(vga_status));

  always #5 clk = ~clk;

  function automatic int hpos(int p); return p % HT; endfunction
  function automatic int vpos(int p); return (p / HT) % VT; endfunction
  function automatic logic [11:0] txt(int p);
    return 12'(hpos(p) * 7 + vpos(p) * 13 + 'h5A3);
  endfunction
  function automatic logic [11:0] grf(int p);
    return 12'((hpos(p) * 29) ^ (vpos(p) * 5) ^ 'hC3C);
  endfunction
  function automatic logic [11:0] cur(int p);
    return ((hpos(p) + vpos(p)) % 3 == 0) ? 12'h000 : 12'(hpos(p) * vpos(p) * 11 + 'h0F1);
  endfunction
  function automatic logic [11:0] pix_for(int p, logic [19:0] c, logic [15:0] fc);
    if (!(hpos(p) < HA && vpos(p) < VA)) return 12'h000;
    case (c[1:0])
      2'd0: return txt(p);
      2'd1: return grf(p);
      2'd3: return c[19:8];
      default: return (cur(p) != 0 && (!c[2] || !fc[BSH])) ? cur(p) : txt(p);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h (tick %0d)", nm, act, exp, n);
    end else passed++;
  endtask

  // behavioural model: position is derived purely from the number of ticks since reset
  initial forever begin
    logic ld, nirq, npend;
    @(posedge clk);
    if (rst) begin
      n = 0; mshadow = 0; mcfg = 0; mpend = 0; mirq = 0; mframe = 0;
      {er, eg, eb} = 12'h000; ehs = 1; evs = 1;
    end else begin
      ld = pix_ce && hpos(n) == 0 && vpos(n) == VA;
      if (pix_ce) begin
        if (n >= RL) begin
          {er, eg, eb} = pix_for(n - RL, mcfg, mframe);
          ehs = !(hpos(n - RL) >= HA + HFP && hpos(n - RL) < HA + HFP + HSY);
          evs = !(vpos(n - RL) >= VA + VFP && vpos(n - RL) < VA + VFP + VSY);
        end
        n++;
      end
      nirq = (ld && mcfg[3]) || (mirq && !irq_clr);
      npend = we_reg || (mpend && !ld);
      if (ld) begin mcfg = mshadow; mframe++; end
      if (we_reg) mshadow = data_in[19:0];
      mirq = nirq; mpend = npend;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("col", 32'(col_o), 32'(hpos(n)));
      chk("row", 32'(row_o), 32'(vpos(n)));
      chk("rgb", 32'({r, g, b}), 32'({er, eg, eb}));
      chk("hsync", 32'(hsync), 32'(ehs));
      chk("vsync", 32'(vsync), 32'(evs));
      chk("irq", 32'(irq), 32'(mirq));
      chk("status", vga_status, {mframe, 11'b0, mirq, mpend, vpos(n) >= VA, mcfg[1:0]});
    end
  end

  task automatic cyc(input logic pce, input logic we, input logic [31:0] d, input logic clr, input logic rs);
    pix_ce = pce; we_reg = we; data_in = d; irq_clr = clr; rst = rs;
    text_color = (n >= RL) ? txt(n - RL) : 12'h000;
    graph_color = (n >= RL) ? grf(n - RL) : 12'h000;
    cursor_color = (n >= RL) ? cur(n - RL) : 12'h000;
    @(negedge clk); #1;
  endtask

  initial begin
    @(negedge clk); #1;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("rst_status", vga_status, 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_col", 32'(col_o), 32'h0);
    cyc(1, 1, 32'h9, 0, 0);
    chk("wr_pending", vga_status, 32'h8);
    chk("wr_col", 32'(col_o), 32'h1);
    while (n != HT * VA) cyc(1, 0, 0, 0, 0);
    chk("pre_load_status", vga_status, 32'hC);
    chk("pre_load_row", 32'(row_o), 32'(VA));
    cyc(1, 0, 0, 1, 0);
    chk("load_status", vga_status, 32'h0001_0005);
    while (n != HT * VT + HT * VA) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk("irq_set_wins", 32'(irq), 32'h1);
    chk("irq_status", vga_status, 32'h0002_0015);
    cyc(1, 0, 0, 1, 0);
    chk("irq_cleared", 32'(irq), 32'h0);
    while (vpos(n) != 5) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h0000_0A53, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("midrst_status", vga_status, 32'h0);
    chk("midrst_row", 32'(row_o), 32'h0);
    chk("midrst_rgb", 32'({r, g, b}), 32'h0);
    chk("midrst_hsync", 32'(hsync), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (k == 3) chk("lat_blank", 32'({r, g, b}), 32'h0);
      if (k == 4) chk("lat_pixel", 32'({r, g, b}), 32'h5A3);
      cyc(0, 0, 0, 0, 0);
      chk("stall_col", 32'(col_o), 32'(k));
    end
    chk("stall_hold", 32'({r, g, b}), 32'h5A3);
    for (int i = 0; i < 30000; i++) begin
      logic at_load;
      logic pce;
      at_load = hpos(n) == 0 && vpos(n) == VA;
      pce = $urandom_range(0, 9) < 7;
      cyc(pce, $urandom_range(0, 149) == 0, $urandom,
          (at_load && pce) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0),
          $urandom_range(0, 5999) == 0);
    end
    cyc(1, 0, 0, 0, 0);
    $display("%0d errors, %0d/%0d checks passed", errors, passed, total);
    $finish;
  end
endmodule
